// File: rtl/serial_word_feeder_if.sv
// Load handshake and serial output bundle for serial_word_feeder.
interface serial_word_feeder_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             w;
  logic             w_valid;
  logic             busy;

  modport master (output data_in, load_valid, input load_ready, w, w_valid, busy);
  modport slave  (input data_in, load_valid, output load_ready, w, w_valid, busy);
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: one-word hold buffer, gapless bit stream on w.
// Optional macro SER_PARITY_EN appends an even-parity bit after every word.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               Clock,
  input logic               Resetn,
  serial_word_feeder_if.slave bus
);

`ifdef SER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam int unsigned CW = $clog2(FRAME + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_next;
  logic [FRAME-1:0] sr, sr_next, frame;
  logic [CW-1:0]    bit_cnt, cnt_next;
  logic [WIDTH-1:0] hr, hr_next, reload_word;
  logic             hold_full, hold_full_next;
  logic             w_next, w_valid_next;
  logic             accept, last, reload;

  // Frame layout puts the parity bit where the shifter reaches it after the data bits.
  function automatic logic [FRAME-1:0] make_frame(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
    return MSB_FIRST ? {d, ^d} : {^d, d};
`else
    return d;
`endif
  endfunction

  function automatic logic first_bit(input logic [FRAME-1:0] f);
    return MSB_FIRST ? f[FRAME-1] : f[0];
  endfunction

  function automatic logic [FRAME-1:0] shift(input logic [FRAME-1:0] f);
    return MSB_FIRST ? (f << 1) : (f >> 1);
  endfunction

  assign accept = bus.load_valid & bus.load_ready;
  assign last   = (state == SHIFT) && (bit_cnt == '0);

  // State register
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last && !hold_full && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and datapath next values; bit_cnt holds bits still to follow the one on w
  always_comb begin
    sr_next        = sr;
    cnt_next       = bit_cnt;
    hr_next        = hr;
    hold_full_next = hold_full;
    w_next         = 1'b0;
    w_valid_next   = 1'b0;
    reload         = 1'b0;
    reload_word    = bus.data_in;
    case (state)
      IDLE: if (accept) reload = 1'b1;
      SHIFT: begin
        if (!last) begin
          w_next       = first_bit(sr);
          w_valid_next = 1'b1;
          sr_next      = shift(sr);
          cnt_next     = bit_cnt - CW'(1);
          if (accept) begin
            hr_next        = bus.data_in;
            hold_full_next = 1'b1;
          end
        end else if (hold_full) begin
          reload         = 1'b1;
          reload_word    = hr;
          hold_full_next = 1'b0;
        end else if (accept) begin
          reload = 1'b1;
        end
      end
      default: ;
    endcase
    frame = make_frame(reload_word);
    if (reload) begin
      w_next       = first_bit(frame);
      w_valid_next = 1'b1;
      sr_next      = shift(frame);
      cnt_next     = CW'(FRAME - 1);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sr             <= '0;
      bit_cnt        <= '0;
      hr             <= '0;
      hold_full      <= 1'b0;
      bus.w          <= 1'b0;
      bus.w_valid    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.load_ready <= 1'b1;
    end else begin
      sr             <= sr_next;
      bit_cnt        <= cnt_next;
      hr             <= hr_next;
      hold_full      <= hold_full_next;
      bus.w          <= w_next;
      bus.w_valid    <= w_valid_next;
      bus.busy       <= (state_next == SHIFT) | hold_full_next;
      bus.load_ready <= ~hold_full_next;
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder; build with SER_PARITY_EN for the LSB-first parity variant.
module tb_serial_word_feeder;
  localparam int unsigned WIDTH = 4;
`ifdef SER_PARITY_EN
  localparam bit          MSB_FIRST = 1'b0;
  localparam int unsigned FRAME     = WIDTH + 1;
`else
  localparam bit          MSB_FIRST = 1'b1;
  localparam int unsigned FRAME     = WIDTH;
`endif

  logic Clock = 1'b0;
  logic Resetn;
  logic exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_bits   = 0;

  serial_word_feeder_if #(.WIDTH(WIDTH)) bus();

  serial_word_feeder #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  // Expected serial order of one word (data bits, then parity when enabled).
  task automatic push_expect(input logic [WIDTH-1:0] word);
    for (int i = 0; i < int'(WIDTH); i++)
      exp_q.push_back(MSB_FIRST ? word[WIDTH-1-i] : word[i]);
`ifdef SER_PARITY_EN
    exp_q.push_back(^word);
`endif
  endtask

  // Present a word until it is accepted; returns cycles spent with load_ready low.
  task automatic drive_word(input logic [WIDTH-1:0] word, output int stalls);
    bit acc;
    acc    = 1'b0;
    stalls = 0;
    push_expect(word);
    bus.data_in    = word;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = bus.load_ready;
      if (!acc) stalls++;
      cycle();
    end
    bus.load_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: word %b never accepted", word);
    end
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && bus.w_valid === 1'b1; i++) cycle();
  endtask

  // Monitor: every valid serial bit must match the head of the scoreboard.
  always @(negedge Clock) begin
    if (bus.w_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_bit: got w=%b with no expected bit pending at %0t", bus.w, $time);
      end else begin
        check("w_bit", 32'(bus.w), 32'(exp_q.pop_front()));
        n_bits++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, vcnt, lr_rise, b0;
    logic [WIDTH-1:0] words[4];
    words = '{4'b1011, 4'b0000, 4'b0110, 4'b1000};

    bus.data_in    = '0;
    bus.load_valid = 1'b0;
    Resetn         = 1'b0;
    cycle();
    cycle();
    check("rst_w", 32'(bus.w), 0);
    check("rst_w_valid", 32'(bus.w_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_load_ready", 32'(bus.load_ready), 1);
    Resetn = 1'b1;
    cycle();

    // Single word: FRAME valid cycles starting at the accepting edge, then idle.
    b0 = n_bits;
    drive_word(4'b1001, st);
    check("single_stall", 32'(st), 0);
    for (int i = 0; i < int'(FRAME); i++) begin
      check("single_valid", 32'(bus.w_valid), 1);
      cycle();
    end
    check("single_end_valid", 32'(bus.w_valid), 0);
    check("single_end_busy", 32'(bus.busy), 0);
    check("single_end_w", 32'(bus.w), 0);
    check("single_bits", 32'(n_bits - b0), 32'(FRAME));

    // Back-to-back: second word parks in the hold register, stream stays contiguous.
    drive_word(4'b1111, st);
    vcnt = (bus.w_valid === 1'b1) ? 1 : 0;
    drive_word(4'b1001, st);
    check("b2b_hold_ready", 32'(bus.load_ready), 0);
    check("b2b_hold_busy", 32'(bus.busy), 1);
    lr_rise = -1;
    for (int k = 0; k < 40 && bus.w_valid === 1'b1; k++) begin
      vcnt++;
      if (lr_rise < 0 && bus.load_ready === 1'b1) lr_rise = k;
      cycle();
    end
    check("b2b_valid_run", 32'(vcnt), 32'(2 * FRAME));
    check("b2b_ready_return", 32'(lr_rise), 32'(FRAME - 1));
    check("b2b_queue_empty", 32'(exp_q.size()), 0);

    // Backpressure: third word must wait until the hold register drains.
    b0 = n_bits;
    drive_word(4'b1111, st);
    drive_word(4'b1001, st);
    drive_word(4'b0110, st);
    check("bp_stalls", 32'(st), 32'(FRAME - 1));
    drain(60);
    check("bp_idle", 32'(bus.w_valid), 0);
    check("bp_bits", 32'(n_bits - b0), 32'(3 * FRAME));
    check("bp_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-frame with the hold register full.
    b0 = n_bits;
    drive_word(4'b1001, st);
    drive_word(4'b1111, st);
    check("mid_hold_ready", 32'(bus.load_ready), 0);
    Resetn = 1'b0;
    cycle();
    exp_q.delete();
    check("mid_bits_before_rst", 32'(n_bits - b0), 2);
    check("mid_rst_valid", 32'(bus.w_valid), 0);
    check("mid_rst_ready", 32'(bus.load_ready), 1);
    check("mid_rst_busy", 32'(bus.busy), 0);
    cycle();
    Resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("mid_post_valid", 32'(bus.w_valid), 0);
    end

    // Stream of mixed words presented back-to-back.
    b0 = n_bits;
    foreach (words[i]) drive_word(words[i], st);
    drain(80);
    check("stream_bits", 32'(n_bits - b0), 32'(4 * FRAME));
    check("stream_queue_empty", 32'(exp_q.size()), 0);
    check("stream_idle_busy", 32'(bus.busy), 0);
    check("stream_idle_ready", 32'(bus.load_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
